// File: rtl/uart_tx_periph.sv
// uart_tx_periph -- byte-wide FIFO feeding an 8N1 serial transmitter.
//
// Ports
//   clk        system clock, all state on its rising edge
//   rst        synchronous active-high reset
//   we         write strobe, one cycle = one byte pushed
//   wdata      byte to queue, sampled when we=1
//   clr_ovf    pulse that clears the sticky overflow flag
//   txd        registered serial output, idle high
//   status     [0] empty, [1] full, [2] busy, [3] overflow,
//              [FIFO_AW+4:4] count, other bits 0
//   irq_empty  one-cycle pulse when the last queued frame finishes
module uart_tx_periph #(
    parameter int BAUD_DIV = 868,
    parameter int FIFO_AW  = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        we,
    input  logic [7:0]  wdata,
    input  logic        clr_ovf,
    output logic        txd,
    output logic [31:0] status,
    output logic        irq_empty
);
    localparam int               DEPTH     = 2 ** FIFO_AW;
    localparam logic [FIFO_AW:0] DEPTH_C   = DEPTH[FIFO_AW:0];
    localparam logic [15:0]      BAUD_LAST = 16'(BAUD_DIV - 1);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_e;

    state_e               state_q, state_d;
    logic [7:0]           mem_q [DEPTH];
    logic [FIFO_AW-1:0]   rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
    logic [FIFO_AW:0]     count_q, count_d;
    logic [15:0]          baud_q, baud_d;
    logic [2:0]           bit_q, bit_d;
    logic [7:0]           shreg_q, shreg_d;
    logic                 txd_q, txd_d;
    logic                 irq_q, irq_d;
    logic                 ovf_q, ovf_d;
    logic                 pop, push, baud_done, have_data;

    assign baud_done = (baud_q == '0);
    assign have_data = (count_q != '0);

    // A full FIFO still accepts a write when the head leaves on the same edge.
    assign push = we && ((count_q != DEPTH_C) || pop);

    // TX FSM next state. Every state or bit change reloads the baud counter
    // so each state/bit lasts exactly BAUD_DIV cycles.
    always_comb begin
        state_d = state_q;
        baud_d  = baud_q;
        bit_d   = bit_q;
        shreg_d = shreg_q;
        txd_d   = txd_q;
        irq_d   = 1'b0;
        pop     = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (have_data) begin
                    pop     = 1'b1;
                    shreg_d = mem_q[rd_ptr_q];
                    txd_d   = 1'b0;
                    baud_d  = BAUD_LAST;
                    state_d = START;
                end
            end
            START: begin
                if (baud_done) begin
                    txd_d   = shreg_q[0];
                    bit_d   = 3'd0;
                    baud_d  = BAUD_LAST;
                    state_d = DATA;
                end else begin
                    baud_d = baud_q - 16'd1;
                end
            end
            DATA: begin
                if (baud_done) begin
                    baud_d = BAUD_LAST;
                    if (bit_q == 3'd7) begin
                        txd_d   = 1'b1;
                        state_d = STOP;
                    end else begin
                        // shreg[0] is the bit on the wire; shift the next one in.
                        txd_d   = shreg_q[1];
                        shreg_d = {1'b0, shreg_q[7:1]};
                        bit_d   = bit_q + 3'd1;
                    end
                end else begin
                    baud_d = baud_q - 16'd1;
                end
            end
            STOP: begin
                if (baud_done) begin
                    // Uses registered count: a write landing on this edge is
                    // picked up from IDLE one edge later.
                    if (have_data) begin
                        pop     = 1'b1;
                        shreg_d = mem_q[rd_ptr_q];
                        txd_d   = 1'b0;
                        baud_d  = BAUD_LAST;
                        state_d = START;
                    end else begin
                        irq_d   = 1'b1;
                        state_d = IDLE;
                    end
                end else begin
                    baud_d = baud_q - 16'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // FIFO pointers, count and overflow.
    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        ovf_d    = ovf_q;
        if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
        if (push) wr_ptr_d = wr_ptr_q + 1'b1;
        if (push && !pop)      count_d = count_q + 1'b1;
        else if (pop && !push) count_d = count_q - 1'b1;
        // A dropped write outranks a clear in the same cycle.
        if (we && !push) ovf_d = 1'b1;
        else if (clr_ovf) ovf_d = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
            baud_q   <= '0;
            bit_q    <= '0;
            shreg_q  <= '0;
            txd_q    <= 1'b1;
            irq_q    <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
            baud_q   <= baud_d;
            bit_q    <= bit_d;
            shreg_q  <= shreg_d;
            txd_q    <= txd_d;
            irq_q    <= irq_d;
            ovf_q    <= ovf_d;
        end
    end

    // Storage needs no reset; pointers and count define what is valid.
    always_ff @(posedge clk) begin
        if (!rst && push) mem_q[wr_ptr_q] <= wdata;
    end

    always_comb begin
        status                = '0;
        status[0]             = (count_q == '0);
        status[1]             = (count_q == DEPTH_C);
        status[2]             = (state_q != IDLE);
        status[3]             = ovf_q;
        status[FIFO_AW+4:4]   = count_q;
    end

    assign txd       = txd_q;
    assign irq_empty = irq_q;
endmodule

// File: tb/tb_uart_tx_periph.sv
// Bench for uart_tx_periph (BAUD_DIV=4, FIFO_AW=3). A frame-level model
// (byte queue + position inside the current 10-bit frame) predicts txd,
// status and irq_empty each cycle; a serial monitor decodes txd into bytes;
// directed tests add hand-computed literal expectations.
module tb_uart_tx_periph;
    localparam int B     = 4;
    localparam int AW    = 3;
    localparam int DEPTH = 8;
    localparam int FL    = 10 * B;

    logic        clk = 1'b0, rst = 1'b1, we = 1'b0, clr_ovf = 1'b0;
    logic [7:0]  wdata = 8'h00;
    logic        txd, irq_empty;
    logic [31:0] status;

    uart_tx_periph #(.BAUD_DIV(B), .FIFO_AW(AW)) dut (
        .clk(clk), .rst(rst), .we(we), .wdata(wdata), .clr_ovf(clr_ovf),
        .txd(txd), .status(status), .irq_empty(irq_empty)
    );

    always #5 clk = ~clk;

    int n_chk = 0, n_pass = 0, cyc = 0;

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s at edge %0d: got %h expected %h", name, cyc, act, exp);
    endtask

    // ---------------- model ----------------
    logic [7:0] mq[$];
    logic [7:0] m_cur = 8'h00;
    bit         m_act = 0, m_ovf = 0, m_irq = 0;
    int         m_pc = 0;
    bit         mp_pop, mp_push;
    int         mp_sz;

    always @(posedge clk) begin
        cyc++;
        if (rst) begin
            mq.delete(); m_act = 0; m_pc = 0; m_ovf = 0; m_irq = 0;
        end else begin
            mp_sz  = mq.size();
            mp_pop = 0;
            m_irq  = 0;
            if (m_act) begin
                if (m_pc == FL - 1) begin
                    if (mp_sz > 0) mp_pop = 1;
                    else begin m_act = 0; m_irq = 1; end
                end else m_pc++;
            end else if (mp_sz > 0) mp_pop = 1;
            mp_push = we && (mp_sz < DEPTH || mp_pop);
            if (mp_pop) begin m_cur = mq.pop_front(); m_act = 1; m_pc = 0; end
            if (mp_push) mq.push_back(wdata);
            if (we && !mp_push) m_ovf = 1;
            else if (clr_ovf) m_ovf = 0;
        end
    end

    function automatic logic exp_txd();
        int k;
        if (!m_act) return 1'b1;
        k = m_pc / B;
        if (k == 0) return 1'b0;
        if (k == 9) return 1'b1;
        return m_cur[k-1];
    endfunction

    function automatic logic [31:0] exp_status();
        logic [31:0] s;
        s = '0;
        s[0] = (mq.size() == 0);
        s[1] = (mq.size() == DEPTH);
        s[2] = m_act;
        s[3] = m_ovf;
        s[AW+4:4] = (AW+1)'(mq.size());
        return s;
    endfunction

    bit chk_en = 0;
    always @(negedge clk) begin
        if (chk_en) begin
            check("txd", {31'b0, txd}, {31'b0, exp_txd()});
            check("status", status, exp_status());
            check("irq_empty", {31'b0, irq_empty}, {31'b0, m_irq});
        end
    end

    // ---------------- serial monitor / irq counter ----------------
    logic [7:0] rx_q[$];
    logic [7:0] exp_q[$];
    logic [7:0] mon_byte = 8'h00;
    bit         mon_busy = 0;
    int         mon_cnt = 0, mon_first = -1;
    int         irq_total = 0, irq_edge = -1;

    always @(negedge clk) begin
        if (rst) mon_busy = 0;
        else if (!mon_busy) begin
            if (txd === 1'b0) begin
                mon_busy = 1; mon_cnt = 0;
                if (mon_first < 0) mon_first = cyc;
            end
        end else begin
            mon_cnt++;
            if (mon_cnt % B == B/2 && mon_cnt / B >= 1 && mon_cnt / B <= 8)
                mon_byte[mon_cnt/B - 1] = txd;
            if (mon_cnt == 9*B + B/2) begin
                check("stop_bit", {31'b0, txd}, 32'd1);
                rx_q.push_back(mon_byte);
                mon_busy = 0;
            end
        end
    end

    always @(negedge clk) begin
        if (irq_empty === 1'b1) begin irq_total++; irq_edge = cyc; end
    end

    // ---------------- helpers ----------------
    task automatic wait_until(int x);
        while (cyc < x) @(negedge clk);
        if (cyc != x) check("schedule", cyc, x);
    endtask

    task automatic wait_irq(int bound);
        int start = irq_total;
        int n = 0;
        while (irq_total == start && n < bound) begin @(negedge clk); n++; end
        if (irq_total == start) check("irq_timeout", 32'd0, 32'd1);
    endtask

    task automatic check_rx(string name);
        check({name, "_len"}, rx_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < rx_q.size(); i++)
            check(name, {24'b0, rx_q[i]}, {24'b0, exp_q[i]});
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    int e0, i0;

    initial begin
        // reset
        repeat (3) @(negedge clk);
        check("rst_status", status, 32'h0000_0001);
        check("rst_txd", {31'b0, txd}, 32'd1);
        check("rst_irq", {31'b0, irq_empty}, 32'd0);
        rst = 1'b0;
        chk_en = 1;
        repeat (2) @(negedge clk);

        // single byte, latency, write on the STOP->IDLE edge
        rx_q.delete();
        we = 1'b1; wdata = 8'hA5;
        @(negedge clk); we = 1'b0; e0 = cyc;
        check("lat_count", status, 32'h0000_0010);
        check("lat_txd_hi", {31'b0, txd}, 32'd1);
        @(negedge clk);
        check("lat_txd_lo", {31'b0, txd}, 32'd0);
        check("lat_busy", status, 32'h0000_0005);
        wait_until(e0 + 40);
        check("stop_level", {31'b0, txd}, 32'd1);
        we = 1'b1; wdata = 8'h96;
        @(negedge clk); we = 1'b0;
        check("idle_irq", {31'b0, irq_empty}, 32'd1);
        check("idle_push", status, 32'h0000_0010);
        @(negedge clk);
        check("idle_pop", status, 32'h0000_0005);
        check("idle_pop_txd", {31'b0, txd}, 32'd0);
        wait_irq(100);
        check("irq2_edge", irq_edge, e0 + 82);
        repeat (5) @(negedge clk);
        check("idle_status", status, 32'h0000_0001);
        exp_q = '{8'hA5, 8'h96};
        check_rx("rx_single");

        // back-to-back
        rx_q.delete(); mon_first = -1; i0 = irq_total;
        we = 1'b1; wdata = 8'h55;
        @(negedge clk); wdata = 8'h0F;
        @(negedge clk); we = 1'b0;
        wait_irq(200);
        check("b2b_span", irq_edge - mon_first, 32'd80);
        repeat (10) @(negedge clk);
        check("b2b_irq_cnt", irq_total - i0, 32'd1);
        exp_q = '{8'h55, 8'h0F};
        check_rx("rx_b2b");

        // fill, overflow, clear, push+pop at full
        rx_q.delete();
        for (int i = 0; i < 10; i++) begin
            we = 1'b1; wdata = 8'hC0 + 8'(i);
            @(negedge clk);
            if (i == 0) e0 = cyc;
            if (i == 8) check("full", status, 32'h0000_0086);
            if (i == 9) check("overflow", status, 32'h0000_008E);
        end
        wdata = 8'hCA; clr_ovf = 1'b1;
        @(negedge clk);
        check("ovf_set_wins", status, 32'h0000_008E);
        we = 1'b0;
        @(negedge clk); clr_ovf = 1'b0;
        check("ovf_clr", status, 32'h0000_0086);
        wait_until(e0 + 40);
        we = 1'b1; wdata = 8'hD0;
        @(negedge clk); we = 1'b0;
        check("push_pop_full", status, 32'h0000_0086);
        for (int f = 0; f < 10 && status[0] !== 1'b1 || status[2] === 1'b1; f++) begin
            if (f >= 12) break;
            wait_irq(600);
            repeat (2) @(negedge clk);
        end
        exp_q = '{8'hC0, 8'hC1, 8'hC2, 8'hC3, 8'hC4, 8'hC5, 8'hC6, 8'hC7, 8'hC8, 8'hD0};
        check_rx("rx_full");

        // reset mid-frame
        rx_q.delete();
        for (int i = 0; i < 4; i++) begin
            we = 1'b1; wdata = 8'h11 * 8'(i + 1);
            @(negedge clk);
            if (i == 0) e0 = cyc;
        end
        we = 1'b0;
        wait_until(e0 + 17);
        rst = 1'b1;
        @(negedge clk);
        check("rst_mid_txd", {31'b0, txd}, 32'd1);
        check("rst_mid_status", status, 32'h0000_0001);
        @(negedge clk); rst = 1'b0;
        mon_first = -1;
        repeat (60) @(negedge clk);
        check("rst_no_toggle", mon_first, -1);
        check("rst_rx_len", rx_q.size(), 32'd0);
        we = 1'b1; wdata = 8'h3C;
        @(negedge clk); we = 1'b0;
        wait_irq(100);
        exp_q = '{8'h3C};
        check_rx("rx_after_rst");

        // pointer wrap: 20 bytes in bursts of 5
        rx_q.delete(); exp_q.delete();
        for (int b = 0; b < 4; b++) begin
            for (int k = 0; k < 5; k++) begin
                we = 1'b1; wdata = 8'(b * 5 + k);
                exp_q.push_back(8'(b * 5 + k));
                @(negedge clk);
            end
            we = 1'b0;
            wait_irq(400);
        end
        repeat (3) @(negedge clk);
        check_rx("rx_wrap");

        repeat (5) @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
